reg_wb_ctrl: RTL and testbench
==============================

# reg_wb_ctrl

Register-bank sequencer: the initiator side of the register bank's read/write/PC ports. Accepts one decoded operation at a time from the decoder over a valid/ready handshake. Drives the bank read selects, captures both operands and hands them to the ALU. Waits for the ALU result, then issues a single write-back and a PC update to the bank. It sits between the decoder/ALU and the register bank and is the only block that drives the bank's `wr_*` and `pc_*` inputs.

## Interface
- `PC_IDX`, 0: bank index holding the PC.
- `TIMEOUT`, 16: EXEC-cycle limit (only with `REG_WB_TIMEOUT_EN`).
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: decoder offers an operation.
- `op_ready` out 1: sequencer can accept an operation.
- `op_src` in 4: source register index.
- `op_dst` in 4: destination register index.
- `op_wb` in 1: write the ALU result to `op_dst`.
- `op_jump` in 1: load the PC with `op_target`.
- `op_target` in 16: jump target.
- `src_reg` out 4: bank read select A.
- `dst_reg` out 4: bank read select B.
- `a` in 16: bank read data A (combinational from `src_reg`).
- `b` in 16: bank read data B (combinational from `dst_reg`).
- `pc_cur` in 16: bank PC output.
- `alu_a` out 16: captured operand A.
- `alu_b` out 16: captured operand B.
- `alu_start` out 1: one-cycle ALU start pulse.
- `alu_y` in 16: ALU result.
- `alu_done` in 1: ALU result valid.
- `wr_reg` out 4: bank write index.
- `wr_data` out 16: bank write data.
- `wr_en` out 1: bank write enable.
- `pc_data_in` out 16: next PC value.
- `pc_inc` out 1: bank PC update strobe.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: timeout flag pulse.

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE. Transitions are unconditional except where noted below.
- IDLE:
  - `op_ready`=1.
  - When `op_valid` is high, latch `op_*`, load `src_reg`=`op_src` and `dst_reg`=`op_dst`, and go to READ.
- READ (one cycle):
  - Register `a`→`alu_a` and `b`→`alu_b`.
  - Set `alu_start` for the next cycle, then go to EXEC.
- EXEC:
  - `alu_start` is high only in the first EXEC cycle.
  - `alu_done` is sampled in every EXEC cycle, including the first.
  - On `alu_done`, capture `alu_y` and go to WB.
- WB (one cycle), with `wr_en`, `pc_inc` and `wr_data` registered so they are valid for exactly this cycle:
  - `wr_en`=`op_wb` AND (`op_dst`≠`PC_IDX`); `wr_reg`=`op_dst`; `wr_data`=captured result.
  - `pc_inc`=1 always.
  - `pc_data_in` is selected in this priority order:
    1. `op_target` if `op_jump`.
    2. Otherwise the result if `op_wb` AND `op_dst`=`PC_IDX`.
    3. Otherwise (`pc_cur`+1) mod 2^16.
  - Because of rule 2, PC writes never go through `wr_en`, and `wr_en` and `pc_inc` never target the same bank entry in the same cycle.
- `op_*` are ignored outside IDLE.
- `alu_y` and `alu_done` are ignored outside EXEC.
- Arithmetic is 16-bit unsigned. `0xFFFF`+1 wraps to `0x0000`.

## Timing
- Reset: state IDLE. After reset, all outputs are 0 except `op_ready`=1.
- Minimum operation latency is 4 cycles:
  - Cycle 0: handshake in IDLE.
  - Cycle 1: READ.
  - Cycle 2: EXEC with `alu_done` already high.
  - Cycle 3: WB.
  - Cycle 4: IDLE, `op_ready`=1.
- Maximum throughput is one operation per 4 cycles. Each extra EXEC cycle adds one cycle.
- `src_reg`/`dst_reg` hold their values from READ until the next accepted operation.
- `alu_a`/`alu_b` hold their values until the next READ.
- `rst` asserted in any state:
  - The FSM returns to IDLE on the next edge.
  - The in-flight operation is dropped: no `wr_en`, no `pc_inc`.
  - If `rst` coincides with WB, the WB strobes of that cycle still reach the bank; `rst` clears them on the following edge.

## Configuration
- `REG_WB_TIMEOUT_EN` defined: an EXEC cycle counter resets on READ→EXEC. If `alu_done` has not been seen after `TIMEOUT` EXEC cycles:
  - The FSM goes to WB with `wr_en` forced to 0.
  - `pc_data_in`=`pc_cur`+1; `op_jump` is ignored.
  - `err`=1 for that WB cycle.
  - `alu_done` arriving in the same cycle as expiry wins: normal write-back, `err`=0.
- `REG_WB_TIMEOUT_EN` undefined: EXEC waits indefinitely, `err` is tied to 0, and no counter is built.

## Test plan
- Basic write-back: bank r3=`0x0005`, r4=`0x0007`, `pc_cur`=`0x0010`. Issue `op_src`=3, `op_dst`=4, `op_wb`=1; ALU returns `0x000C` in the first EXEC cycle. Expect `alu_a`=5, `alu_b`=7, a 1-cycle `alu_start`, and in cycle 3 `wr_en`=1, `wr_reg`=4, `wr_data`=`0x000C`, `pc_inc`=1, `pc_data_in`=`0x0011`.
- Jump plus PC wrap: `op_jump`=1, `op_target`=`0x0200` → `pc_data_in`=`0x0200`, `wr_en`=0. Then `pc_cur`=`0xFFFF` with no jump → `pc_data_in`=`0x0000`.
- PC destination: `op_dst`=0, `op_wb`=1, result `0x1234` → `wr_en`=0, `pc_data_in`=`0x1234`.
- Handshake and stall: hold `op_valid`=1 continuously with `alu_done` delayed 5 cycles. Expect exactly one operation accepted per IDLE cycle, `op_ready`=0 for 8 cycles, and the second operation's READ following IDLE.
- Reset in EXEC: assert `rst` while waiting for `alu_done` → no `wr_en`/`pc_inc` pulse; the cycle after reset shows `op_ready`=1 and `busy`=0.
- Timeout (`REG_WB_TIMEOUT_EN`, `TIMEOUT`=4): no `alu_done` → WB after 4 EXEC cycles with `err`=1, `wr_en`=0, `pc_data_in`=`pc_cur`+1. Repeat with `alu_done` on the 4th EXEC cycle → `err`=0 and normal write-back.

Source files
------------

// File: rtl/reg_wb_ctrl_if.sv
// Bundle of the sequencer's decoder, register-bank and ALU signals.
// master is the sequencer's view; slave is the surrounding decoder/bank/ALU view.
interface reg_wb_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_src;
    logic [3:0]  op_dst;
    logic        op_wb;
    logic        op_jump;
    logic [15:0] op_target;
    logic [3:0]  src_reg;
    logic [3:0]  dst_reg;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pc_cur;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_start;
    logic [15:0] alu_y;
    logic        alu_done;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        wr_en;
    logic [15:0] pc_data_in;
    logic        pc_inc;
    logic        busy;
    logic        err;

    modport master (
        input  op_valid, op_src, op_dst, op_wb, op_jump, op_target,
        input  a, b, pc_cur, alu_y, alu_done,
        output op_ready, src_reg, dst_reg, alu_a, alu_b, alu_start,
        output wr_reg, wr_data, wr_en, pc_data_in, pc_inc, busy, err
    );

    modport slave (
        output op_valid, op_src, op_dst, op_wb, op_jump, op_target,
        output a, b, pc_cur, alu_y, alu_done,
        input  op_ready, src_reg, dst_reg, alu_a, alu_b, alu_start,
        input  wr_reg, wr_data, wr_en, pc_data_in, pc_inc, busy, err
    );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Register-bank sequencer: IDLE -> READ -> EXEC -> WB, one operation at a time.
// Optional EXEC timeout with err flag is built only when REG_WB_TIMEOUT_EN is defined.
module reg_wb_ctrl #(
    parameter int unsigned PC_IDX  = 0,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    reg_wb_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] PC_SEL = 4'(PC_IDX);

    if (PC_IDX > 15) begin : g_bad_pc_idx
        $error("reg_wb_ctrl: PC_IDX must be 0..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("reg_wb_ctrl: TIMEOUT must be at least 1");
    end

    state_t      state;
    state_t      state_next;
    logic        op_wb_q;
    logic        op_jump_q;
    logic [15:0] op_target_q;
    logic        timeout_hit;
    logic [15:0] pc_plus1;

    assign pc_plus1     = bus.pc_cur + 16'd1;
    assign bus.op_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.op_valid) state_next = READ;
            READ: state_next = EXEC;
            EXEC: if (bus.alu_done || timeout_hit) state_next = WB;
            WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes default low every cycle so each is high for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.src_reg    <= '0;
            bus.dst_reg    <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_start  <= 1'b0;
            bus.wr_reg     <= '0;
            bus.wr_data    <= '0;
            bus.wr_en      <= 1'b0;
            bus.pc_data_in <= '0;
            bus.pc_inc     <= 1'b0;
            op_wb_q        <= 1'b0;
            op_jump_q      <= 1'b0;
            op_target_q    <= '0;
        end else begin
            bus.alu_start <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.pc_inc    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        bus.src_reg <= bus.op_src;
                        bus.dst_reg <= bus.op_dst;
                        op_wb_q     <= bus.op_wb;
                        op_jump_q   <= bus.op_jump;
                        op_target_q <= bus.op_target;
                    end
                end
                READ: begin
                    bus.alu_a     <= bus.a;
                    bus.alu_b     <= bus.b;
                    bus.alu_start <= 1'b1;
                end
                EXEC: begin
                    // A result arriving on the expiry cycle takes precedence over the timeout.
                    if (bus.alu_done) begin
                        bus.wr_en   <= op_wb_q && (bus.dst_reg != PC_SEL);
                        bus.wr_reg  <= bus.dst_reg;
                        bus.wr_data <= bus.alu_y;
                        bus.pc_inc  <= 1'b1;
                        if (op_jump_q) begin
                            bus.pc_data_in <= op_target_q;
                        end else if (op_wb_q && (bus.dst_reg == PC_SEL)) begin
                            bus.pc_data_in <= bus.alu_y;
                        end else begin
                            bus.pc_data_in <= pc_plus1;
                        end
                    end else if (timeout_hit) begin
                        bus.wr_reg     <= bus.dst_reg;
                        bus.pc_inc     <= 1'b1;
                        bus.pc_data_in <= pc_plus1;
                    end
                end
                WB: begin
                end
                default: begin
                end
            endcase
        end
    end

`ifdef REG_WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] exec_cnt;
    logic             err_q;

    // exec_cnt numbers EXEC cycles from 0, so expiry falls on the TIMEOUT-th cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_cnt <= '0;
        end else if (state == READ) begin
            exec_cnt <= '0;
        end else if (state == EXEC) begin
            exec_cnt <= exec_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == EXEC) && (exec_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit && !bus.alu_done;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed cases from the operation rules plus
// randomized operations checked against a transaction-level expectation per operation.
module tb_reg_wb_ctrl;
    localparam int unsigned T   = 4;
    localparam logic [3:0]  PCI = 4'd0;
`ifdef REG_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    reg_wb_ctrl_if bus();

    reg_wb_ctrl #(.PC_IDX(0), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    logic [15:0] bank [16];
    assign bus.a = bank[bus.src_reg];
    assign bus.b = bank[bus.dst_reg];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble(input bit hold);
        bus.op_valid  = hold ? 1'b1 : 1'($urandom);
        bus.op_src    = 4'($urandom);
        bus.op_dst    = 4'($urandom);
        bus.op_wb     = 1'($urandom);
        bus.op_jump   = 1'($urandom);
        bus.op_target = 16'($urandom);
    endtask

    // Called at a falling edge with the sequencer idle; returns at the falling edge after WB.
    task automatic run_op(input logic [3:0] src, input logic [3:0] dst, input bit wb,
                          input bit jump, input logic [15:0] target, input logic [15:0] pc,
                          input logic [15:0] y, input int unsigned d, input bit hold,
                          input bit rst_wb);
        int unsigned busy_n;
        int unsigned n_exec;
        bit          to;
        bit          exp_we;
        logic [15:0] exp_pc;
        busy_n = 0;
        to     = TO_EN && (d > T - 1);
        n_exec = to ? T : d + 1;
        if (to) begin
            exp_we = 1'b0;
            exp_pc = pc + 16'd1;
        end else begin
            exp_we = wb && (dst != PCI);
            if (jump)                  exp_pc = target;
            else if (wb && dst == PCI) exp_pc = y;
            else                       exp_pc = pc + 16'd1;
        end

        check("idle_ready", bus.op_ready, 1);
        check("idle_busy", bus.busy, 0);
        bus.op_valid  = 1'b1;
        bus.op_src    = src;
        bus.op_dst    = dst;
        bus.op_wb     = wb;
        bus.op_jump   = jump;
        bus.op_target = target;
        bus.pc_cur    = pc;

        @(negedge clk);
        busy_n += 32'(!bus.op_ready);
        check("read_busy", bus.busy, 1);
        check("src_reg", bus.src_reg, src);
        check("dst_reg", bus.dst_reg, dst);
        scramble(hold);
        bus.alu_done = 1'($urandom);
        bus.alu_y    = 16'($urandom);

        @(negedge clk);
        check("alu_a", bus.alu_a, bank[src]);
        check("alu_b", bus.alu_b, bank[dst]);
        check("alu_start_first", bus.alu_start, 1);
        for (int unsigned k = 0; k < n_exec; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("alu_start_later", bus.alu_start, 0);
            end
            busy_n += 32'(!bus.op_ready);
            check("exec_no_wr", {bus.wr_en, bus.pc_inc}, 0);
            bus.alu_done = (k == d);
            bus.alu_y    = (k == d) ? y : 16'($urandom);
            scramble(hold);
        end

        @(negedge clk);
        busy_n += 32'(!bus.op_ready);
        check("wb_wr_en", bus.wr_en, exp_we);
        check("wb_wr_reg", bus.wr_reg, dst);
        if (!to) check("wb_wr_data", bus.wr_data, y);
        check("wb_pc_inc", bus.pc_inc, 1);
        check("wb_pc_data", bus.pc_data_in, exp_pc);
        check("wb_err", bus.err, to);
        check("wb_start_low", bus.alu_start, 0);
        bus.alu_done = 1'($urandom);
        bus.alu_y    = 16'($urandom);
        scramble(hold);
        if (rst_wb) rst = 1'b1;

        @(negedge clk);
        rst = 1'b0;
        check("done_ready", bus.op_ready, 1);
        check("done_strobes", {bus.wr_en, bus.pc_inc, bus.err}, 0);
        check("busy_cycles", busy_n, n_exec + 2);
        bus.op_valid = hold;
    endtask

    task automatic rst_in_exec();
        check("rx_ready", bus.op_ready, 1);
        bus.op_valid  = 1'b1;
        bus.op_src    = 4'd6;
        bus.op_dst    = 4'd7;
        bus.op_wb     = 1'b1;
        bus.op_jump   = 1'b1;
        bus.op_target = 16'h4444;
        bus.alu_done  = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rx_waiting", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.alu_done = 1'b1;
        bus.alu_y    = 16'hBEEF;
        check("rx_ready_after", bus.op_ready, 1);
        check("rx_busy_after", bus.busy, 0);
        check("rx_strobes", {bus.wr_en, bus.pc_inc, bus.alu_start, bus.err}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rx_quiet", {bus.wr_en, bus.pc_inc, bus.busy}, 0);
        end
        bus.alu_done = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 16'($urandom);
        rst           = 1'b1;
        bus.op_valid  = 1'b0;
        bus.op_src    = '0;
        bus.op_dst    = '0;
        bus.op_wb     = 1'b0;
        bus.op_jump   = 1'b0;
        bus.op_target = '0;
        bus.pc_cur    = '0;
        bus.alu_y     = '0;
        bus.alu_done  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.op_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_sel", {bus.src_reg, bus.dst_reg, bus.wr_reg}, 0);
        check("rst_alu", {bus.alu_a, bus.alu_b}, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_pc_data", bus.pc_data_in, 0);
        check("rst_strobes", {bus.alu_start, bus.wr_en, bus.pc_inc, bus.err}, 0);

        bank[3] = 16'h0005;
        bank[4] = 16'h0007;
        run_op(4'd3, 4'd4, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h000C, 0, 1'b0, 1'b0);
        run_op(4'd2, 4'd5, 1'b0, 1'b1, 16'h0200, 16'h0040, 16'h9999, 1, 1'b0, 1'b0);
        run_op(4'd1, 4'd2, 1'b0, 1'b0, 16'h0300, 16'hFFFF, 16'h5555, 0, 1'b0, 1'b0);
        run_op(4'd2, 4'd0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h1234, 2, 1'b0, 1'b0);
        run_op(4'd5, 4'd0, 1'b1, 1'b1, 16'h0ABC, 16'h0100, 16'h1234, 0, 1'b0, 1'b0);
        run_op(4'd7, 4'd8, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'hA5A5, 5, 1'b1, 1'b0);
        run_op(4'd9, 4'd10, 1'b1, 1'b0, 16'h0000, 16'h0021, 16'h5A5A, 5, 1'b1, 1'b0);
        run_op(4'd11, 4'd12, 1'b1, 1'b0, 16'h0000, 16'h0022, 16'h0F0F, 0, 1'b0, 1'b0);
        run_op(4'd1, 4'd6, 1'b1, 1'b1, 16'h7000, 16'h0030, 16'h1111, 3, 1'b0, 1'b0);
        run_op(4'd1, 4'd6, 1'b1, 1'b1, 16'h7000, 16'h0031, 16'h2222, 9, 1'b0, 1'b0);
        run_op(4'd13, 4'd14, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h3333, 1, 1'b0, 1'b1);
        rst_in_exec();

        for (int n = 0; n < 40; n++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom), 16'($urandom),
                   $urandom_range(0, 6), 1'($urandom), 1'b0);
        end
        bus.op_valid = 1'b0;
        @(negedge clk);
        check("end_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
